exe_stage_module: RTL and testbench

//  Execute stage of the 5-stage ARM pipeline: generates Val2 (immediate rotate / register shift / memory offset),

---
 rtl/arm_pkg.sv | 37 +++
 rtl/exe_stage_module_if.sv | 49 ++++
 rtl/arm_alu.sv | 48 ++++
 rtl/exe_stage_module.sv | 119 +++++++++++
 tb/tb_exe_stage_module.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU opcodes, shift types, forward selects.
package arm_pkg;

  localparam logic [3:0] ExeMov = 4'b0001;
  localparam logic [3:0] ExeMvn = 4'b1001;
  localparam logic [3:0] ExeAdd = 4'b0010;
  localparam logic [3:0] ExeAdc = 4'b0011;
  localparam logic [3:0] ExeSub = 4'b0100;
  localparam logic [3:0] ExeSbc = 4'b0101;
  localparam logic [3:0] ExeAnd = 4'b0110;
  localparam logic [3:0] ExeOrr = 4'b0111;
  localparam logic [3:0] ExeEor = 4'b1000;

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [1:0] ShRor = 2'b11;

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdMem = 2'b01;
  localparam logic [1:0] FwdWb  = 2'b10;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Rotate right; the low half of the doubled word shifted right is the rotation.
  function automatic logic [31:0] ror32(input logic [31:0] val, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {val, val} >> amt;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/exe_stage_module_if.sv
// ID/EX inputs and EXE/MEM outputs of the execute stage, grouped as one bundle.
interface exe_stage_module_if;
  logic        freeze;
  logic        flush;
  logic [3:0]  EXE_CMD_IN;
  logic        MEM_R_EN_IN;
  logic        MEM_W_EN_IN;
  logic        WB_EN_IN;
  logic        S_IN;
  logic        B_IN;
  logic        imm_IN;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [31:0] Val_Rn;
  logic [31:0] Val_Rm;
  logic [3:0]  Dest_IN;
  logic [31:0] PC_IN;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] MEM_ALU_result;
  logic [31:0] WB_value;

  logic [31:0] ALU_result;
  logic [31:0] Val_Rm_OUT;
  logic [31:0] PC;
  logic [3:0]  Dest;
  logic        WB_EN;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [3:0]  status;
  logic        branch_taken;
  logic [31:0] branch_address;

  modport master (
    output freeze, flush, EXE_CMD_IN, MEM_R_EN_IN, MEM_W_EN_IN, WB_EN_IN, S_IN, B_IN, imm_IN,
           Shift_operand, Signed_imm_24, Val_Rn, Val_Rm, Dest_IN, PC_IN, sel_src1, sel_src2,
           MEM_ALU_result, WB_value,
    input  ALU_result, Val_Rm_OUT, PC, Dest, WB_EN, MEM_R_EN, MEM_W_EN, status, branch_taken,
           branch_address
  );

  modport slave (
    input  freeze, flush, EXE_CMD_IN, MEM_R_EN_IN, MEM_W_EN_IN, WB_EN_IN, S_IN, B_IN, imm_IN,
           Shift_operand, Signed_imm_24, Val_Rn, Val_Rm, Dest_IN, PC_IN, sel_src1, sel_src2,
           MEM_ALU_result, WB_value,
    output ALU_result, Val_Rm_OUT, PC, Dest, WB_EN, MEM_R_EN, MEM_W_EN, status, branch_taken,
           branch_address
  );
endinterface

// File: rtl/arm_alu.sv
// 32-bit ALU; carry and overflow come from a 33-bit sum, logic ops clear C and V.
module arm_alu
  import arm_pkg::*;
(
  input  logic [3:0]  exe_cmd_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        carry_i,
  output logic [31:0] result_o,
  output nzcv_t       flags_o
);

  logic [32:0] sum;
  logic        c;
  logic        v;

  always_comb begin
    sum      = '0;
    result_o = '0;
    c        = 1'b0;
    v        = 1'b0;
    case (exe_cmd_i)
      ExeMov: result_o = b_i;
      ExeMvn: result_o = ~b_i;
      ExeAdd, ExeAdc: begin
        sum      = {1'b0, a_i} + {1'b0, b_i} + {32'd0, (exe_cmd_i == ExeAdc) & carry_i};
        result_o = sum[31:0];
        c        = sum[32];
        v        = (a_i[31] == b_i[31]) && (result_o[31] != a_i[31]);
      end
      ExeSub, ExeSbc: begin
        // a - b - !C == a + ~b + C; SUB is the C=1 case, so carry out is not-borrow.
        sum      = {1'b0, a_i} + {1'b0, ~b_i}
                 + {32'd0, (exe_cmd_i == ExeSub) | carry_i};
        result_o = sum[31:0];
        c        = sum[32];
        v        = (a_i[31] != b_i[31]) && (result_o[31] != a_i[31]);
      end
      ExeAnd: result_o = a_i & b_i;
      ExeOrr: result_o = a_i | b_i;
      ExeEor: result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

  assign flags_o = '{n: result_o[31], z: (result_o == 32'd0), c: c, v: v};

endmodule

// File: rtl/exe_stage_module.sv
// Execute stage: operand forwarding, Val2 shifter, ALU, NZCV register, EXE/MEM register.
// Define EXE_FORWARDING_EN to enable the Rn/Rm forwarding muxes.
module exe_stage_module
  import arm_pkg::*;
(
  input logic                clk,
  input logic                rst,
  exe_stage_module_if.slave  bus
);

  logic [31:0] rn;
  logic [31:0] rm;
  logic [31:0] val2;
  logic [31:0] alu_res;
  nzcv_t       alu_flags;
  logic [4:0]  shamt;

  logic [31:0] alu_result_q;
  logic [31:0] val_rm_q;
  logic [31:0] pc_q;
  logic [3:0]  dest_q;
  logic        wb_en_q;
  logic        mem_r_en_q;
  logic        mem_w_en_q;
  nzcv_t       status_q;

`ifdef EXE_FORWARDING_EN
  always_comb begin
    case (bus.sel_src1)
      FwdMem:  rn = bus.MEM_ALU_result;
      FwdWb:   rn = bus.WB_value;
      default: rn = bus.Val_Rn;
    endcase
    case (bus.sel_src2)
      FwdMem:  rm = bus.MEM_ALU_result;
      FwdWb:   rm = bus.WB_value;
      default: rm = bus.Val_Rm;
    endcase
  end
`else
  // Hazard unit stalls instead; forwarding inputs exist but are ignored.
  logic unused_fwd;
  assign unused_fwd = ^{bus.sel_src1, bus.sel_src2, bus.MEM_ALU_result, bus.WB_value};
  assign rn = bus.Val_Rn;
  assign rm = bus.Val_Rm;
`endif

  assign shamt = bus.Shift_operand[11:7];

  always_comb begin
    val2 = '0;
    if (bus.MEM_R_EN_IN || bus.MEM_W_EN_IN) begin
      val2 = {20'd0, bus.Shift_operand};
    end else if (bus.imm_IN) begin
      val2 = ror32({24'd0, bus.Shift_operand[7:0]}, {bus.Shift_operand[11:8], 1'b0});
    end else begin
      case (bus.Shift_operand[6:5])
        ShLsl:   val2 = rm << shamt;
        ShLsr:   val2 = rm >> shamt;
        ShAsr:   val2 = $signed(rm) >>> shamt;
        default: val2 = ror32(rm, shamt);
      endcase
    end
  end

  arm_alu u_alu (
    .exe_cmd_i (bus.EXE_CMD_IN),
    .a_i       (rn),
    .b_i       (val2),
    .carry_i   (status_q.c),
    .result_o  (alu_res),
    .flags_o   (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
    end else if (bus.S_IN && !bus.freeze && !bus.flush) begin
      status_q <= alu_flags;
    end
  end

  // Flush beats freeze so a squashed instruction never reaches memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= '0;
      val_rm_q     <= '0;
      pc_q         <= '0;
      dest_q       <= '0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
    end else if (bus.flush) begin
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
    end else if (!bus.freeze) begin
      alu_result_q <= alu_res;
      val_rm_q     <= rm;
      pc_q         <= bus.PC_IN;
      dest_q       <= bus.Dest_IN;
      wb_en_q      <= bus.WB_EN_IN;
      mem_r_en_q   <= bus.MEM_R_EN_IN;
      mem_w_en_q   <= bus.MEM_W_EN_IN;
    end
  end

  assign bus.ALU_result     = alu_result_q;
  assign bus.Val_Rm_OUT     = val_rm_q;
  assign bus.PC             = pc_q;
  assign bus.Dest           = dest_q;
  assign bus.WB_EN          = wb_en_q;
  assign bus.MEM_R_EN       = mem_r_en_q;
  assign bus.MEM_W_EN       = mem_w_en_q;
  assign bus.status         = status_q;
  assign bus.branch_taken   = bus.B_IN;
  assign bus.branch_address = bus.PC_IN + {{6{bus.Signed_imm_24[23]}}, bus.Signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage_module.sv
// Table-driven bench for exe_stage_module with a queue scoreboard for EXE/MEM outputs.
module tb_exe_stage_module;
  import arm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_stage_module_if bus ();

  exe_stage_module dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic        mr, mw, wb, s, imm;
    logic [11:0] so;
    logic [31:0] rn, rm;
    logic [3:0]  dest;
    logic [31:0] pc;
    logic [31:0] res;
    logic [3:0]  st;
  } vec_t;

  typedef struct {
    logic [31:0] res, rm_out, pc;
    logic [3:0]  dest;
    logic        wb, mr, mw;
    logic [3:0]  st;
  } exp_t;

  vec_t vecs[15];
  exp_t sb_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, " ALU_result"}, bus.ALU_result, e.res);
    chk({tag, " Val_Rm_OUT"}, bus.Val_Rm_OUT, e.rm_out);
    chk({tag, " PC"}, bus.PC, e.pc);
    chk({tag, " Dest"}, {28'd0, bus.Dest}, {28'd0, e.dest});
    chk({tag, " WB_EN"}, {31'd0, bus.WB_EN}, {31'd0, e.wb});
    chk({tag, " MEM_R_EN"}, {31'd0, bus.MEM_R_EN}, {31'd0, e.mr});
    chk({tag, " MEM_W_EN"}, {31'd0, bus.MEM_W_EN}, {31'd0, e.mw});
    chk({tag, " status"}, {28'd0, bus.status}, {28'd0, e.st});
  endtask

  task automatic drive(input vec_t v);
    bus.EXE_CMD_IN    = v.cmd;
    bus.MEM_R_EN_IN   = v.mr;
    bus.MEM_W_EN_IN   = v.mw;
    bus.WB_EN_IN      = v.wb;
    bus.S_IN          = v.s;
    bus.imm_IN        = v.imm;
    bus.Shift_operand = v.so;
    bus.Val_Rn        = v.rn;
    bus.Val_Rm        = v.rm;
    bus.Dest_IN       = v.dest;
    bus.PC_IN         = v.pc;
  endtask

  // Push expectation, advance one edge, pop and compare.
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_out(tag, got);
  endtask

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.res = v.res; e.rm_out = v.rm; e.pc = v.pc; e.dest = v.dest;
    e.wb = v.wb; e.mr = v.mr; e.mw = v.mw; e.st = v.st;
    return e;
  endfunction

  initial begin
    exp_t e;
    vec_t v;
    //            cmd    mr    mw    wb    s     imm   so       rn            rm            dst   pc            res           st
    vecs[0]  = '{ExeAdd, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h0,        4'd3, 32'h0000_0010, 32'h80000000, 4'b1001};
    vecs[1]  = '{ExeSub, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h005, 32'h5,        32'h0,        4'd4, 32'h0000_0014, 32'h0,        4'b0110};
    vecs[2]  = '{ExeAdc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 32'h1,        32'h0,        4'd5, 32'h0000_0018, 32'h3,        4'b0110};
    vecs[3]  = '{ExeMov, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h4FF, 32'h0,        32'h0,        4'd6, 32'h0000_001C, 32'hFF000000, 4'b0110};
    vecs[4]  = '{ExeMov, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h220, 32'h0,        32'hF0,       4'd7, 32'h0000_0020, 32'h0000000F, 4'b0110};
    vecs[5]  = '{ExeMov, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h460, 32'h0,        32'hAB,       4'd8, 32'h0000_0024, 32'hAB000000, 4'b0110};
    vecs[6]  = '{ExeMvn, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 32'h0,        32'h0,        4'd1, 32'h0000_0028, 32'hFFFFFFFF, 4'b1000};
    vecs[7]  = '{ExeSbc, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h003, 32'h10,       32'h0,        4'd2, 32'h0000_002C, 32'h0000000C, 4'b0010};
    vecs[8]  = '{ExeAnd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'hF0F0,     32'hFF0F,     4'd9, 32'h0000_0030, 32'h0000F000, 4'b0010};
    vecs[9]  = '{ExeOrr, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h00F, 32'hF000,     32'h0,        4'd10, 32'h0000_0034, 32'h0000F00F, 4'b0010};
    vecs[10] = '{ExeEor, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h00F, 32'hFF,       32'h0,        4'd11, 32'h0000_0038, 32'h000000F0, 4'b0000};
    vecs[11] = '{ExeMov, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h240, 32'h0,        32'h80000000, 4'd12, 32'h0000_003C, 32'hF8000000, 4'b1000};
    vecs[12] = '{ExeMov, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h080, 32'h0,        32'h1,        4'd13, 32'h0000_0040, 32'h2,        4'b1000};
    vecs[13] = '{ExeAdd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF, 32'h100,      32'h0,        4'd14, 32'h0000_0044, 32'h000010FF, 4'b1000};
    vecs[14] = '{ExeAdd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h004, 32'h200,      32'hDEADBEEF, 4'd0, 32'h0000_0048, 32'h00000204, 4'b1000};

    bus.freeze = 1'b0; bus.flush = 1'b0; bus.B_IN = 1'b0; bus.Signed_imm_24 = '0;
    bus.sel_src1 = FwdReg; bus.sel_src2 = FwdReg; bus.MEM_ALU_result = '0; bus.WB_value = '0;
    drive(vecs[0]);
    e = '{res: 32'h0, rm_out: 32'h0, pc: 32'h0, dest: 4'h0, wb: 1'b0, mr: 1'b0, mw: 1'b0, st: 4'h0};

    // Reset holds everything at zero regardless of inputs.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", e);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      last_exp = to_exp(vecs[i]);
      step($sformatf("vec%0d", i), last_exp);
    end

    // Freeze: new ADD with S=1 must not disturb outputs or status.
    v = '{ExeAdd, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h001, 32'h1, 32'h0, 4'd9, 32'h0000_0100,
          32'h2, 4'b0000};
    drive(v);
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("freeze%0d", i), last_exp);
    bus.freeze = 1'b0;
    last_exp = to_exp(v);
    step("unfreeze", last_exp);

    // Flush of an LDR with S=1: controls cleared, status untouched.
    v = '{ExeAdd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0FF, 32'h80000000, 32'h0, 4'd7, 32'h0,
          32'h0, 4'b0000};
    drive(v);
    bus.flush = 1'b1;
    bus.freeze = 1'b1;
    @(posedge clk);
    #1;
    chk("flush WB_EN", {31'd0, bus.WB_EN}, 32'd0);
    chk("flush MEM_R_EN", {31'd0, bus.MEM_R_EN}, 32'd0);
    chk("flush MEM_W_EN", {31'd0, bus.MEM_W_EN}, 32'd0);
    chk("flush status", {28'd0, bus.status}, 32'd0);
    bus.flush = 1'b0;
    bus.freeze = 1'b0;

    // Branch outputs are combinational.
    bus.S_IN = 1'b0;
    bus.B_IN = 1'b1;
    bus.Signed_imm_24 = 24'hFFFFFE;
    bus.PC_IN = 32'h100;
    #1;
    chk("branch_taken", {31'd0, bus.branch_taken}, 32'd1);
    chk("branch_address back", bus.branch_address, 32'h000000F8);
    bus.Signed_imm_24 = 24'h000010;
    #1;
    chk("branch_address fwd", bus.branch_address, 32'h00000140);
    bus.B_IN = 1'b0;
    #1;
    chk("branch_not_taken", {31'd0, bus.branch_taken}, 32'd0);

    // Forwarding: Rn from MEM stage, Rm (store data) from WB.
    v = '{ExeAdd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h002, 32'h0, 32'h1, 4'd2, 32'h200,
          32'h2, 4'b0000};
    drive(v);
    bus.sel_src1 = FwdMem; bus.MEM_ALU_result = 32'h10;
    bus.sel_src2 = FwdWb;  bus.WB_value = 32'hCAFE0000;
    e = to_exp(v);
`ifdef EXE_FORWARDING_EN
    e.res = 32'h12;
    e.rm_out = 32'hCAFE0000;
`endif
    step("forward", e);

    // Select 11 behaves like register select.
    bus.sel_src1 = 2'b11; bus.sel_src2 = 2'b11;
    v.rn = 32'h5; v.res = 32'h7; v.rm = 32'h33;
    drive(v);
    step("sel11", to_exp(v));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
